// File: rtl/uart_bridge_pkg.sv
// Shared constants and types for the UART-to-register-bus bridge.
//   - frame opcodes and response bytes
//   - bridge FSM state encoding
//   - guard reload values for the UART toggle handshakes
package uart_bridge_pkg;

  localparam logic [7:0] OP_WR   = 8'h57;  // 'W' : W, AH, AL, D
  localparam logic [7:0] OP_RD   = 8'h52;  // 'R' : R, AH, AL
  localparam logic [7:0] RSP_ACK = 8'h2B;  // '+' : write completed
  localparam logic [7:0] RSP_BAD = 8'h3F;  // '?' : unknown opcode
  localparam logic [7:0] RSP_TMO = 8'h21;  // '!' : bus timeout

  // RX guard spans the UART's 1-cycle byte latency plus its 1-cycle ready lag.
  localparam logic [1:0] RX_GUARD_RELOAD = 2'd3;
  localparam logic [1:0] TX_GUARD_RELOAD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_AH,
    ST_GET_AL,
    ST_GET_D,
    ST_BUS_REQ,
    ST_BUS_WAIT,
    ST_SEND_RESP
  } bridge_state_e;

endpackage

// File: rtl/uart_bus_bridge_link.sv
// uart_toggle_link: toggle-handshake adapter between the UART FIFOs and the
// bridge FSM.
//   RX: uart_rx_ready/uart_rx_byte in, uart_rx_read toggle out;
//       rx_en (FSM wants a byte) in, rx_valid/rx_data (one-cycle strobe) out.
//   TX: uart_tx_fifo_full in, uart_tx_start toggle / uart_tx_data out;
//       tx_valid/tx_byte in, tx_ready out (byte taken when both high).
// Synchronous active-low reset rst_n.
module uart_toggle_link
  import uart_bridge_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx_ready,
  input  logic [7:0] uart_rx_byte,
  output logic       uart_rx_read,
  output logic       uart_tx_start,
  output logic [7:0] uart_tx_data,
  input  logic       uart_tx_fifo_full,
  input  logic       rx_en,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       tx_valid,
  input  logic [7:0] tx_byte,
  output logic       tx_ready
);

  logic [1:0] rx_guard_q, rx_guard_d;
  logic       rx_read_q,  rx_read_d;
  logic [7:0] rx_data_q,  rx_data_d;
  logic [1:0] tx_guard_q, tx_guard_d;
  logic       tx_start_q, tx_start_d;
  logic [7:0] tx_data_q,  tx_data_d;

  assign uart_rx_read  = rx_read_q;
  assign uart_tx_start = tx_start_q;
  assign uart_tx_data  = tx_data_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = (rx_guard_q == 2'd1);
  assign tx_ready      = !uart_tx_fifo_full && (tx_guard_q == 2'd0);

  always_comb begin
    rx_guard_d = rx_guard_q;
    rx_read_d  = rx_read_q;
    rx_data_d  = rx_data_q;
    if (rx_guard_q != 2'd0) begin
      rx_guard_d = rx_guard_q - 2'd1;
      // Byte is captured on the edge where the guard steps down to 1.
      if (rx_guard_q == 2'd2) rx_data_d = uart_rx_byte;
    end else if (rx_en && uart_rx_ready) begin
      rx_read_d  = ~rx_read_q;
      rx_guard_d = RX_GUARD_RELOAD;
    end

    tx_guard_d = tx_guard_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    if (tx_guard_q != 2'd0) begin
      tx_guard_d = tx_guard_q - 2'd1;
    end else if (tx_valid && tx_ready) begin
      tx_data_d  = tx_byte;
      tx_start_d = ~tx_start_q;
      tx_guard_d = TX_GUARD_RELOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_guard_q <= '0;
      rx_read_q  <= 1'b0;
      rx_data_q  <= '0;
      tx_guard_q <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      rx_guard_q <= rx_guard_d;
      rx_read_q  <= rx_read_d;
      rx_data_q  <= rx_data_d;
      tx_guard_q <= tx_guard_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

endmodule

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: parses host command frames from the UART RX FIFO and runs
// single-beat register-bus transfers; responses go to the UART TX FIFO.
//   Frames: 'W' AH AL D (write), 'R' AH AL (read; response = read data).
//   Responses: '?' bad opcode, '!' bus timeout, '+' write done (optional).
// Ports: clk, rst_n (synchronous, active-low); UART RX toggle side
// (uart_rx_ready, uart_rx_byte, uart_rx_read); UART TX toggle side
// (uart_tx_start, uart_tx_data, uart_tx_fifo_full); register bus (bus_addr,
// bus_wdata, bus_we, bus_re, bus_rdata, bus_ack); err_count (saturating).
// Build option: define UART_BRIDGE_WR_ACK_EN to answer every completed write
// with '+'; otherwise successful writes are silent.
module uart_bus_bridge
  import uart_bridge_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int BUS_TIMEOUT   = 255,
  parameter int FRAME_TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx_ready,
  input  logic [7:0]        uart_rx_byte,
  output logic              uart_rx_read,
  output logic              uart_tx_start,
  output logic [7:0]        uart_tx_data,
  input  logic              uart_tx_fifo_full,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  output logic              bus_we,
  output logic              bus_re,
  input  logic [7:0]        bus_rdata,
  input  logic              bus_ack,
  output logic [7:0]        err_count
);

  localparam int BT_W = $clog2(BUS_TIMEOUT + 1);
  localparam int FT_W = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [BT_W-1:0] BT_LAST  = BT_W'(BUS_TIMEOUT - 1);
  localparam logic [FT_W-1:0] FT_LIMIT = FT_W'(FRAME_TIMEOUT);

  bridge_state_e     state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic [BT_W-1:0]   btmr_q, btmr_d;
  logic [FT_W-1:0]   ftmr_q, ftmr_d;
  logic [7:0]        err_q, err_d;
  logic              rsp_pend_q, rsp_pend_d;
  logic [7:0]        rsp_byte_q, rsp_byte_d;
  logic              err_inc;

  logic       rx_en, rx_valid, tx_ready;
  logic [7:0] rx_data;

  // IDLE holds off fetching while a '?' is still queued, so it cannot be overwritten.
  assign rx_en = ((state_q == ST_IDLE) && !rsp_pend_q) ||
                 (state_q == ST_GET_AH) || (state_q == ST_GET_AL) || (state_q == ST_GET_D);

  uart_toggle_link u_link (
    .clk               (clk),
    .rst_n             (rst_n),
    .uart_rx_ready     (uart_rx_ready),
    .uart_rx_byte      (uart_rx_byte),
    .uart_rx_read      (uart_rx_read),
    .uart_tx_start     (uart_tx_start),
    .uart_tx_data      (uart_tx_data),
    .uart_tx_fifo_full (uart_tx_fifo_full),
    .rx_en             (rx_en),
    .rx_valid          (rx_valid),
    .rx_data           (rx_data),
    .tx_valid          (rsp_pend_q),
    .tx_byte           (rsp_byte_q),
    .tx_ready          (tx_ready)
  );

  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_we    = we_q;
  assign bus_re    = re_q;
  assign err_count = err_q;

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    re_d       = re_q;
    btmr_d     = btmr_q;
    ftmr_d     = '0;
    rsp_pend_d = rsp_pend_q;
    rsp_byte_d = rsp_byte_q;
    err_inc    = 1'b0;

    if (rsp_pend_q && tx_ready) rsp_pend_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_data == OP_WR) begin
            wr_d    = 1'b1;
            state_d = ST_GET_AH;
          end else if (rx_data == OP_RD) begin
            wr_d    = 1'b0;
            state_d = ST_GET_AH;
          end else begin
            rsp_pend_d = 1'b1;
            rsp_byte_d = RSP_BAD;
            err_inc    = 1'b1;
          end
        end
      end
      ST_GET_AH, ST_GET_AL, ST_GET_D: begin
        if (rx_valid) begin
          if (state_q == ST_GET_D) begin
            wdata_d = rx_data;
            state_d = ST_BUS_REQ;
          end else begin
            // Address bytes arrive high first and are shifted in.
            addr_d = {addr_q[ADDR_W-9:0], rx_data};
            if (state_q == ST_GET_AH) state_d = ST_GET_AL;
            else                      state_d = wr_q ? ST_GET_D : ST_BUS_REQ;
          end
        end else if (ftmr_q == FT_LIMIT) begin
          state_d = ST_IDLE;
          err_inc = 1'b1;
        end else begin
          ftmr_d = ftmr_q + 1'b1;
        end
      end
      ST_BUS_REQ: begin
        we_d    = wr_q;
        re_d    = !wr_q;
        btmr_d  = '0;
        state_d = ST_BUS_WAIT;
      end
      ST_BUS_WAIT: begin
        if (bus_ack) begin
          we_d = 1'b0;
          re_d = 1'b0;
          if (!wr_q) begin
            rsp_pend_d = 1'b1;
            rsp_byte_d = bus_rdata;
            state_d    = ST_SEND_RESP;
          end else begin
`ifdef UART_BRIDGE_WR_ACK_EN
            rsp_pend_d = 1'b1;
            rsp_byte_d = RSP_ACK;
            state_d    = ST_SEND_RESP;
`else
            state_d    = ST_IDLE;
`endif
          end
        end else if (btmr_q == BT_LAST) begin
          we_d       = 1'b0;
          re_d       = 1'b0;
          err_inc    = 1'b1;
          rsp_pend_d = 1'b1;
          rsp_byte_d = RSP_TMO;
          state_d    = ST_SEND_RESP;
        end else begin
          btmr_d = btmr_q + 1'b1;
        end
      end
      ST_SEND_RESP: begin
        if (!rsp_pend_q || tx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    err_d = (err_inc && (err_q != '1)) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      btmr_q     <= '0;
      ftmr_q     <= '0;
      err_q      <= '0;
      rsp_pend_q <= 1'b0;
      rsp_byte_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      re_q       <= re_d;
      btmr_q     <= btmr_d;
      ftmr_q     <= ftmr_d;
      err_q      <= err_d;
      rsp_pend_q <= rsp_pend_d;
      rsp_byte_q <= rsp_byte_d;
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Testbench for uart_bus_bridge: a UART/bus peripheral model driven from a
// byte queue, and a frame-level reference model that predicts bus transfers,
// response bytes and the error count.
module tb_uart_bus_bridge;

  localparam int FT = 300;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_rx_ready;
  logic [7:0]  uart_rx_byte;
  logic        uart_rx_read;
  logic        uart_tx_start;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_fifo_full;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [7:0]  bus_rdata;
  logic        bus_ack;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  uart_bus_bridge #(.ADDR_W(16), .BUS_TIMEOUT(255), .FRAME_TIMEOUT(FT)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .uart_rx_ready     (uart_rx_ready),
    .uart_rx_byte      (uart_rx_byte),
    .uart_rx_read      (uart_rx_read),
    .uart_tx_start     (uart_tx_start),
    .uart_tx_data      (uart_tx_data),
    .uart_tx_fifo_full (uart_tx_fifo_full),
    .bus_addr          (bus_addr),
    .bus_wdata         (bus_wdata),
    .bus_we            (bus_we),
    .bus_re            (bus_re),
    .bus_rdata         (bus_rdata),
    .bus_ack           (bus_ack),
    .err_count         (err_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Peripheral model state
  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];
  int          rx_toggles = 0;
  logic        rd_prev, st_prev, stage_v, rdy_lag;
  logic [7:0]  stage_b;
  int          ack_delay;
  logic [7:0]  rd_value;
  int          req_cnt = 0;
  int          txn_cnt = 0;
  int          last_req_cycles = 0;
  logic [15:0] last_addr;
  logic [7:0]  last_wdata;
  logic        last_we;
  int          exp_err = 0;

  // UART: byte appears one cycle after the read toggle is seen; ready lags the queue by a cycle.
  // Bus: acks ack_delay cycles into a request (never when negative); rdata is junk off the ack cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_prev       = uart_rx_read;
      st_prev       = uart_tx_start;
      stage_v       = 1'b0;
      rdy_lag       = 1'b0;
      uart_rx_ready = 1'b0;
      uart_rx_byte  = 8'h00;
      bus_ack       = 1'b0;
      bus_rdata     = 8'h00;
      req_cnt       = 0;
    end else begin
      if (stage_v) begin
        uart_rx_byte = stage_b;
        stage_v      = 1'b0;
      end
      if (uart_rx_read !== rd_prev) begin
        rd_prev = uart_rx_read;
        rx_toggles++;
        stage_b = 8'h00;
        if (rxq.size() != 0) stage_b = rxq.pop_front();
        stage_v = 1'b1;
      end
      uart_rx_ready = rdy_lag;
      rdy_lag       = (rxq.size() != 0);

      if (uart_tx_start !== st_prev) begin
        st_prev = uart_tx_start;
        txq.push_back(uart_tx_data);
      end

      bus_ack   = 1'b0;
      bus_rdata = ~rd_value;
      if (bus_we || bus_re) begin
        if (req_cnt == 0) begin
          txn_cnt++;
          last_addr  = bus_addr;
          last_wdata = bus_wdata;
          last_we    = bus_we;
        end
        if (req_cnt == ack_delay) begin
          bus_ack   = 1'b1;
          bus_rdata = rd_value;
        end
        req_cnt++;
      end else begin
        if (req_cnt != 0) last_req_cycles = req_cnt;
        req_cnt = 0;
      end
    end
  end

  // Feeds one frame (n bytes) and checks it against the frame-level rules.
  task automatic run_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input int n,
                           input int delay, input logic [7:0] rdv);
    int t0, tg0, bn0, exp_tx_n;
    logic [7:0] exp_tx_b;
    logic is_wr, is_rd;
    t0  = txq.size();
    tg0 = rx_toggles;
    bn0 = txn_cnt;
    ack_delay = delay;
    rd_value  = rdv;
    rxq.push_back(b0);
    if (n > 1) rxq.push_back(b1);
    if (n > 2) rxq.push_back(b2);
    if (n > 3) rxq.push_back(b3);
    repeat (n * 8 + ((delay < 0) ? 300 : delay + 10) + 20) @(negedge clk);

    is_wr = (b0 == 8'h57) && (n == 4);
    is_rd = (b0 == 8'h52) && (n == 3);
    exp_tx_n = 0;
    exp_tx_b = 8'h00;
    if (!is_wr && !is_rd) begin
      exp_tx_n = 1; exp_tx_b = 8'h3F;
      if (exp_err < 255) exp_err++;
    end else if (delay < 0) begin
      exp_tx_n = 1; exp_tx_b = 8'h21;
      if (exp_err < 255) exp_err++;
    end else if (is_rd) begin
      exp_tx_n = 1; exp_tx_b = rdv;
    end else begin
`ifdef UART_BRIDGE_WR_ACK_EN
      exp_tx_n = 1; exp_tx_b = 8'h2B;
`endif
    end

    check({tag, "_rx_toggles"}, rx_toggles - tg0, n);
    check({tag, "_bus_txns"}, txn_cnt - bn0, (is_wr || is_rd) ? 1 : 0);
    if (is_wr || is_rd) begin
      check({tag, "_bus_we"}, last_we, is_wr);
      check({tag, "_bus_addr"}, last_addr, {b1, b2});
      if (is_wr) check({tag, "_bus_wdata"}, last_wdata, b3);
      if (delay < 0) check({tag, "_req_cycles"}, last_req_cycles, 255);
      else           check({tag, "_req_cycles"}, last_req_cycles, delay + 1);
    end
    check({tag, "_tx_count"}, txq.size() - t0, exp_tx_n);
    if (exp_tx_n == 1 && txq.size() > t0) check({tag, "_tx_byte"}, txq[t0], exp_tx_b);
    check({tag, "_err_count"}, err_count, exp_err);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_read"}, uart_rx_read, 0);
    check({tag, "_tx_start"}, uart_tx_start, 0);
    check({tag, "_tx_data"}, uart_tx_data, 0);
    check({tag, "_bus_addr"}, bus_addr, 0);
    check({tag, "_bus_wdata"}, bus_wdata, 0);
    check({tag, "_bus_we"}, bus_we, 0);
    check({tag, "_bus_re"}, bus_re, 0);
    check({tag, "_err"}, err_count, 0);
  endtask

  initial begin
    int t0, tg0, bn0, sel, dly;
    logic [7:0] op, ah, al, d, rv;
    rst_n = 1'b0;
    uart_tx_fifo_full = 1'b0;
    ack_delay = -1;
    rd_value  = 8'h00;
    repeat (4) @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    #1 rst_n = 1'b1;

    run_frame("wr",  8'h57, 8'h12, 8'h34, 8'hA5, 4, 3, 8'h00);
    run_frame("rd",  8'h52, 8'h00, 8'h10, 8'h00, 3, 2, 8'h5C);
    run_frame("bad", 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00);
    run_frame("after_bad", 8'h52, 8'hBE, 8'hEF, 8'h00, 3, 0, 8'h3C);
    run_frame("rd_tmo", 8'h52, 8'h40, 8'h02, 8'h00, 3, -1, 8'h00);
    run_frame("wr_tmo", 8'h57, 8'h40, 8'h03, 8'h99, 4, -1, 8'h00);

    // Partial frame then silence.
    t0 = txq.size(); tg0 = rx_toggles; bn0 = txn_cnt;
    rxq.push_back(8'h57);
    rxq.push_back(8'h12);
    repeat (FT + 80) @(negedge clk);
    if (exp_err < 255) exp_err++;
    check("ftmo_rx_toggles", rx_toggles - tg0, 2);
    check("ftmo_bus_txns", txn_cnt - bn0, 0);
    check("ftmo_tx_count", txq.size() - t0, 0);
    check("ftmo_err_count", err_count, exp_err);
    run_frame("after_ftmo", 8'h52, 8'h00, 8'h01, 8'h00, 3, 1, 8'hC3);

    // Response held back while the TX FIFO is full.
    uart_tx_fifo_full = 1'b1;
    t0 = txq.size();
    ack_delay = 2;
    rd_value  = 8'h77;
    rxq.push_back(8'h52); rxq.push_back(8'hAB); rxq.push_back(8'hCD);
    repeat (80) @(negedge clk);
    check("full_bus_addr", last_addr, 16'hABCD);
    check("full_tx_held", txq.size() - t0, 0);
    uart_tx_fifo_full = 1'b0;
    repeat (10) @(negedge clk);
    check("full_tx_count", txq.size() - t0, 1);
    if (txq.size() > t0) check("full_tx_byte", txq[t0], 8'h77);

    // Reset while the bus request is outstanding.
    ack_delay = -1;
    rxq.push_back(8'h52); rxq.push_back(8'h00); rxq.push_back(8'h20);
    for (int i = 0; i < 100 && !bus_re; i++) @(negedge clk);
    check("rst_re_seen", bus_re, 1);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    #1 rst_n = 1'b1;
    rxq.delete();
    exp_err = 0;
    t0 = txq.size();
    repeat (300) @(negedge clk);
    check("midrst_no_tx", txq.size() - t0, 0);
    check("midrst_re_low", bus_re, 0);

    // Randomized frames.
    for (int k = 0; k < 25; k++) begin
      sel = $urandom_range(0, 9);
      ah  = 8'($urandom);
      al  = 8'($urandom);
      d   = 8'($urandom);
      rv  = 8'($urandom);
      dly = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 6);
      if (sel < 4) begin
        run_frame("rnd_wr", 8'h57, ah, al, d, 4, dly, rv);
      end else if (sel < 8) begin
        run_frame("rnd_rd", 8'h52, ah, al, d, 3, dly, rv);
      end else begin
        op = 8'($urandom);
        if (op == 8'h57 || op == 8'h52) op = 8'hFF;
        run_frame("rnd_bad", op, ah, al, d, 1, dly, rv);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
- Command-frame parser that sits downstream of the `uart` block's RX FIFO and upstream of its TX FIFO.
- Pulls bytes through the toggle handshake, decodes read/write frames, and runs single-beat transfers on a simple register bus. Read data and status bytes go back through the UART TX toggle interface.
- Gives a host PC byte-level access to on-chip registers.

Parameters:
- ADDR_W, 16, bus address width; must be 16 (two address bytes per frame).
- BUS_TIMEOUT, 255, max cycles spent in BUS_WAIT before abort; width = $clog2(BUS_TIMEOUT+1).
- FRAME_TIMEOUT, 1000000, max idle cycles between bytes of one frame before the parser returns to IDLE.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- uart_rx_ready  in  1  UART has an RX byte available (registered level)
- uart_rx_byte  in  8  UART RX byte, valid 2 cycles after a read toggle
- uart_rx_read  out  1  toggled once per byte consumed
- uart_tx_start  out  1  toggled once per byte queued
- uart_tx_data  out  8  TX byte; held stable through each toggle
- uart_tx_fifo_full  in  1  UART TX FIFO full
- bus_addr  out  16  register address
- bus_wdata  out  8  write data
- bus_we  out  1  write request; level, held until ack/timeout
- bus_re  out  1  read request; level, held until ack/timeout
- bus_rdata  in  8  read data, sampled on the bus_ack cycle
- bus_ack  in  1  one-cycle completion strobe
- err_count  out  8  saturating count of bad opcodes, frame timeouts and bus timeouts

Behaviour:
- Reset (rst_n=0 at posedge): all outputs 0, FSM=IDLE, guard and timeout counters 0. Reset mid-frame or mid-bus-cycle abandons the frame and drops bus_we/bus_re in the same edge; no response byte is sent.
- Byte fetch:
  - Only when uart_rx_ready=1 and rx guard=0.
  - Toggle uart_rx_read and load rx guard=3.
  - Decrement the guard each cycle; capture uart_rx_byte when it reaches 1.
  - Guard covers the UART's 1-cycle byte latency plus its 1-cycle ready-flag lag, so a stale ready never causes a double read.
- Byte send:
  - Only when uart_tx_fifo_full=0 and tx guard=0.
  - Drive uart_tx_data, toggle uart_tx_start, load tx guard=2.
  - uart_tx_data holds until the guard expires.
- Opcodes: 0x57 'W' = write, frame W,AH,AL,D. 0x52 'R' = read, frame R,AH,AL.
- States:
  - IDLE: fetch byte. 0x57 -> GET_AH with wr=1; 0x52 -> GET_AH with wr=0; any other value -> send 0x3F '?', err_count++, stay IDLE.
  - GET_AH -> GET_AL: capture the address high byte.
  - GET_AL: capture the low byte; -> GET_D if wr, else BUS_REQ.
  - GET_D -> BUS_REQ: capture write data.
  - BUS_REQ: assert bus_we or bus_re, clear the bus timer -> BUS_WAIT.
  - BUS_WAIT:
    - bus_ack -> deassert request on the next edge.
    - Read: latch bus_rdata -> SEND_RESP with byte = rdata.
    - Write: -> IDLE (with ACK feature: SEND_RESP with byte 0x2B).
    - Timer reaching BUS_TIMEOUT -> deassert, err_count++, SEND_RESP with byte 0x21 '!'.
  - SEND_RESP: send one byte -> IDLE.
- bus_ack outside BUS_WAIT is ignored.
- Frame timeout: in GET_AH/GET_AL/GET_D, a counter counts cycles without a fetched byte. At FRAME_TIMEOUT -> IDLE, err_count++, no response.
- err_count saturates at 255; simultaneous error sources in one cycle cannot occur.
- Minimum frame-to-frame turnaround is not guaranteed; throughput is bounded by the guards (4 cycles/byte).

Optional Feature:
- Macro UART_BRIDGE_WR_ACK_EN.
- Defined: every completed write returns 0x2B.
- Undefined: successful writes are silent; timeouts still return 0x21.

Decomposition:
- Package uart_bridge_pkg: opcode constants (OP_WR=8'h57, OP_RD=8'h52), response constants (RSP_ACK=8'h2B, RSP_BAD=8'h3F, RSP_TMO=8'h21), FSM state enum, guard reload values.
- One sub-module: uart_toggle_link, covering both rx and tx toggle handshakes and guard counters, with a valid/ready byte interface toward the FSM.

Test Plan:
- Frame 57 12 34 A5, ack after 3 cycles -> bus_we=1, bus_addr=0x1234, bus_wdata=0xA5 until ack; no TX toggle (0x2B with macro); exactly 4 rx_read toggles.
- Frame 52 00 10, bus_rdata=0x5C with ack -> bus_re=1, addr=0x0010; one TX toggle with uart_tx_data=0x5C.
- Byte 0x00 -> TX 0x3F, err_count=1, FSM IDLE, next valid frame processed normally.
- Read with bus_ack never asserted -> request drops after 255 cycles, TX 0x21, err_count increments.
- Send 57 12, then silence > FRAME_TIMEOUT -> IDLE, err_count++, no bus activity; a following 52 00 01 completes correctly.
- uart_tx_fifo_full=1 during a read response -> no toggle until full drops; rst_n pulsed mid-BUS_WAIT -> all outputs 0 at next edge, no response byte.
